// File: rtl/seg7_bcd_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and reassembles debounced BCD frames.
// Optional macro SEG7_BLANK_EN: all-off pattern decodes to 4'hF and is not flagged invalid.
module seg7_bcd_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:6]  seg,
    input  logic [3:0]  an,
    output logic [15:0] bcd_out,
    output logic        frame_valid,
    output logic        err
);

    typedef enum logic {ACQ, EMIT} state_t;

    localparam logic [7:0]  STABLE   = 8'(STABLE_CYCLES);
    localparam logic [10:0] IDLE_SMP = {4'hF, 7'h7F};

    state_t          r_state;
    logic [10:0]     r_sample;
    logic [10:0]     r_prev;
    logic [7:0]      r_cnt;
    logic [3:0]      r_captured;
    logic [3:0][3:0] r_slots;
    logic            r_acc;

    logic [3:0]      w_an;
    logic [6:0]      w_seg;
    logic            w_legal;
    logic [1:0]      w_idx;
    logic [3:0]      w_val;
    logic            w_inv;
    logic [7:0]      w_cnt_nxt;
    logic            w_cap;
    logic [3:0]      w_onehot;

    assign w_an  = r_sample[10:7];
    assign w_seg = r_sample[6:0];

    always_comb begin
        w_legal = 1'b1;
        w_idx   = 2'd0;
        case (w_an)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_inv = 1'b0;
        w_val = 4'hE;
        case (w_seg)
            7'b0000001: w_val = 4'd0;
            7'b1001111: w_val = 4'd1;
            7'b0010010: w_val = 4'd2;
            7'b0000110: w_val = 4'd3;
            7'b1001100: w_val = 4'd4;
            7'b0100100: w_val = 4'd5;
            7'b0100000: w_val = 4'd6;
            7'b0001111: w_val = 4'd7;
            7'b0000000: w_val = 4'd8;
            7'b0000100: w_val = 4'd9;
`ifdef SEG7_BLANK_EN
            7'b1111111: w_val = 4'hF;
`endif
            default:    w_inv = 1'b1;
        endcase
    end

    // Run length of the registered sample; saturation stops repeat captures.
    always_comb begin
        if (!w_legal)
            w_cnt_nxt = 8'd0;
        else if (r_sample != r_prev)
            w_cnt_nxt = 8'd1;
        else if (r_cnt == STABLE)
            w_cnt_nxt = STABLE;
        else
            w_cnt_nxt = r_cnt + 8'd1;
    end

    assign w_cap    = (w_cnt_nxt == STABLE) && (r_cnt != STABLE) && (r_state == ACQ);
    assign w_onehot = 4'b0001 << w_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ACQ;
            r_sample    <= IDLE_SMP;
            r_prev      <= IDLE_SMP;
            r_cnt       <= 8'd0;
            r_captured  <= 4'b0000;
            r_slots     <= '0;
            r_acc       <= 1'b0;
            bcd_out     <= 16'h0000;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            r_sample    <= {an, seg};
            r_prev      <= r_sample;
            r_cnt       <= w_cnt_nxt;
            frame_valid <= 1'b0;
            if (w_cap)
                r_slots[w_idx] <= w_val;
            case (r_state)
                ACQ: begin
                    if (r_captured == 4'b1111) begin
                        // A capture landing on the frame boundary starts the next frame.
                        r_state     <= EMIT;
                        bcd_out     <= r_slots;
                        err         <= r_acc;
                        frame_valid <= 1'b1;
                        r_captured  <= w_cap ? w_onehot : 4'b0000;
                        r_acc       <= w_cap & w_inv;
                    end else if (w_cap) begin
                        r_captured <= r_captured | w_onehot;
                        r_acc      <= r_acc | w_inv;
                    end
                end
                EMIT: r_state <= ACQ;
                default: r_state <= ACQ;
            endcase
        end
    end

endmodule
